// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet unframer.
// PACKET_UNFRAMER_CHECKSUM_EN adds the CHECK state for the trailing XOR byte.
package pkt_pkg;

  localparam int LEN_W           = 16;
  localparam int BYTE_W          = 8;
  localparam int DEFAULT_MAX_LEN = 1500;

  typedef enum logic [1:0] {
    HDR_HI  = 2'd0,
    HDR_LO  = 2'd1,
    PAYLOAD = 2'd2
`ifdef PACKET_UNFRAMER_CHECKSUM_EN
    , CHECK = 2'd3
`endif
  } unframe_state_t;

  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/unframer_skid_buf.sv
// Two-entry read buffer between the packet FIFO and the unframer parser.
// Tracks occupancy plus the single read in flight and generates the FIFO read enable.
module unframer_skid_buf
  import pkt_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fifo_empty_i,
  input  logic [BYTE_W-1:0] fifo_rdata_i,
  input  logic              pop_i,
  output logic              fifo_ren_o,
  output logic [BYTE_W-1:0] head_o,
  output logic              nonempty_o
);

  logic [BYTE_W-1:0] ent0_q, ent0_d;
  logic [BYTE_W-1:0] ent1_q, ent1_d;
  logic [1:0]        occ_q, occ_d, occ_pop;
  logic              pend_q;
  logic [2:0]        fill;

  // Reads are issued against the occupancy left after this cycle's pop, so a
  // full buffer that is being drained keeps the FIFO streaming.
  always_comb begin
    occ_pop    = occ_q - {1'b0, pop_i};
    fill       = {1'b0, occ_pop} + {2'b00, pend_q};
    fifo_ren_o = n_rst && !fifo_empty_i && (fill < 3'd2);
    ent0_d     = pop_i ? ent1_q : ent0_q;
    ent1_d     = ent1_q;
    if (pend_q) begin
      if (occ_pop == 2'd0) begin
        ent0_d = fifo_rdata_i;
      end else begin
        ent1_d = fifo_rdata_i;
      end
    end
    occ_d = fill[1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
      pend_q <= fifo_ren_o;
    end
  end

  assign head_o     = ent0_q;
  assign nonempty_o = (occ_q != 2'd0);

endmodule

// File: rtl/packet_unframer.sv
// Strips the 2-byte big-endian length header from FIFO bytes and streams the payload.
// Define PACKET_UNFRAMER_CHECKSUM_EN to consume and verify a trailing XOR byte per packet.
module packet_unframer
  import pkt_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fifo_empty,
  input  logic [BYTE_W-1:0] fifo_rdata,
  output logic              fifo_ren,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              len_err,
  output logic              chk_err,
  output logic              busy
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  unframe_state_t    state_q;
  logic [LEN_W-1:0]  len_q, rem_q, len_d;
  logic              len_err_q;
  logic              pop, xfer, buf_nonempty;
  logic [BYTE_W-1:0] head;

  unframer_skid_buf u_buf (
    .clk          (clk),
    .n_rst        (n_rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .pop_i        (pop),
    .fifo_ren_o   (fifo_ren),
    .head_o       (head),
    .nonempty_o   (buf_nonempty)
  );

  // Header and checksum bytes drain one per cycle; payload waits on the consumer.
  always_comb begin
    xfer  = (state_q == PAYLOAD) && buf_nonempty && out_ready;
    pop   = (state_q == PAYLOAD) ? xfer : buf_nonempty;
    len_d = {len_q[LEN_W-1:BYTE_W], head};
  end

  assign out_valid = (state_q == PAYLOAD) && buf_nonempty;
  assign out_data  = head;
  assign out_sop   = out_valid && (rem_q == len_q);
  assign out_eop   = out_valid && (rem_q == ONE);
  assign len_err   = len_err_q;
  assign busy      = (state_q != HDR_HI) || buf_nonempty;

`ifdef PACKET_UNFRAMER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic              chk_err_q;
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= HDR_HI;
      len_q     <= '0;
      rem_q     <= '0;
      len_err_q <= 1'b0;
`ifdef PACKET_UNFRAMER_CHECKSUM_EN
      csum_q    <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      len_err_q <= 1'b0;
`ifdef PACKET_UNFRAMER_CHECKSUM_EN
      chk_err_q <= 1'b0;
`endif
      case (state_q)
        HDR_HI: begin
          if (pop) begin
            len_q[LEN_W-1:BYTE_W] <= head;
            state_q               <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (pop) begin
            len_q <= len_d;
            if (len_legal(len_d, MAX_LEN_C)) begin
              rem_q   <= len_d;
              state_q <= PAYLOAD;
            end else begin
              // Both header bytes are dropped; the next byte starts a new header.
              len_err_q <= 1'b1;
              state_q   <= HDR_HI;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            rem_q <= rem_q - ONE;
`ifdef PACKET_UNFRAMER_CHECKSUM_EN
            csum_q <= out_sop ? head : (csum_q ^ head);
            if (out_eop) state_q <= CHECK;
`else
            if (out_eop) state_q <= HDR_HI;
`endif
          end
        end
`ifdef PACKET_UNFRAMER_CHECKSUM_EN
        CHECK: begin
          if (pop) begin
            chk_err_q <= (head != csum_q);
            state_q   <= HDR_HI;
          end
        end
`endif
        default: state_q <= HDR_HI;
      endcase
    end
  end

endmodule
